// File: rtl/hpu_if_qdec_ras.sv
// Quick pre-decoder for the IF1->IF2 boundary with a speculative return-address stack.
// Build option: define HPU_IF_RAS_EN to instantiate the RAS; otherwise returns predict fall-through.
package hpu_if_qdec_ras_pkg;
  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [PC_W-1:0]   pc_t;

  typedef enum logic [2:0] {
    IS_NORMAL = 3'd0,
    IS_BRANCH = 3'd1,
    IS_JAL    = 3'd2,
    IS_JALR   = 3'd3,
    IS_CALL   = 3'd4,
    IS_RET    = 3'd5
  } qdec_type_e;

  localparam logic [6:0] INST_BR    = 7'b1100011;
  localparam logic [6:0] INST_JAL   = 7'b1101111;
  localparam logic [6:0] INST_JALR  = 7'b1100111;
  localparam logic [6:0] INST_LUI   = 7'b0110111;
  localparam logic [6:0] INST_AUIPC = 7'b0010111;

  localparam logic [4:0] SR_RA = 5'd1;
  localparam logic [4:0] SR_T0 = 5'd5;
endpackage

module hpu_if_qdec_ras
  import hpu_if_qdec_ras_pkg::*;
#(
  parameter  int unsigned FETCH_W   = 2,
  parameter  int unsigned RAS_DEPTH = 8,
  parameter  int unsigned PTR_W     = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W     = $clog2(RAS_DEPTH + 1),
  localparam int unsigned CKPT_W    = PTR_W + CNT_W
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      fetch_vld_i,
  input  inst_t      [FETCH_W-1:0]  fetch_inst_i,
  input  pc_t                       fetch_pc_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic       [CKPT_W-1:0]   flush_ckpt_i,
  output logic                      qdec_vld_o,
  output logic       [FETCH_W-1:0]  qdec_lane_vld_o,
  output qdec_type_e [FETCH_W-1:0]  qdec_type_o,
  output pc_t                       qdec_pred_npc_o,
  output logic       [CKPT_W-1:0]   qdec_ckpt_o
);

  function automatic logic f_is_link(input logic [4:0] r);
    return (r == SR_RA) || (r == SR_T0);
  endfunction

  function automatic pc_t f_j_imm(input inst_t i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic pc_t f_i_imm(input inst_t i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic pc_t f_u_imm(input inst_t i);
    return {i[31:12], 12'h000};
  endfunction

  logic                     r_vld;
  logic       [FETCH_W-1:0] r_lane_vld;
  qdec_type_e [FETCH_W-1:0] r_type;
  pc_t                      r_npc;
  logic                     r_pend_vld;
  pc_t                      r_pend_val;

  logic                     w_pend_vld;
  pc_t                      w_pend_val;
  logic                     w_stop;
  logic       [FETCH_W-1:0] w_lane_vld;
  qdec_type_e [FETCH_W-1:0] w_type;
  pc_t                      w_npc;
  pc_t                      w_lane_pc;
  inst_t                    w_inst;
  qdec_type_e               w_cls;
  pc_t                      w_tgt;
  logic                     w_rd_lnk;
  logic                     w_rs1_lnk;
  logic                     w_swap;

`ifdef HPU_IF_RAS_EN
  typedef enum logic [1:0] {RAS_NOP, RAS_PUSH, RAS_POP, RAS_SWAP} ras_op_e;

  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  pc_t               r_ras [RAS_DEPTH];
  logic [CKPT_W-1:0] r_ckpt;
  ras_op_e           w_ras_op;
  pc_t               w_link;
`else
  logic w_unused_nc;
  assign w_unused_nc = ^{flush_ckpt_i, w_swap};
`endif

  // Lane walk: classify, chain the link-register tracker, stop at the first redirect.
  always_comb begin
    w_pend_vld = r_pend_vld;
    w_pend_val = r_pend_val;
    w_stop     = 1'b0;
    w_lane_vld = '0;
    w_npc      = fetch_pc_i + PC_W'(FETCH_W * 4);
    w_lane_pc  = '0;
    w_inst     = '0;
    w_cls      = IS_NORMAL;
    w_tgt      = '0;
    w_rd_lnk   = 1'b0;
    w_rs1_lnk  = 1'b0;
    w_swap     = 1'b0;
`ifdef HPU_IF_RAS_EN
    w_ras_op   = RAS_NOP;
    w_link     = '0;
`endif
    for (int unsigned l = 0; l < FETCH_W; l++) begin
      w_type[l] = IS_NORMAL;
      w_lane_pc = fetch_pc_i + PC_W'(l * 4);
      w_inst    = fetch_inst_i[l];
      w_rd_lnk  = f_is_link(w_inst[11:7]);
      w_rs1_lnk = f_is_link(w_inst[19:15]);
      w_cls     = IS_NORMAL;
      w_tgt     = w_lane_pc + PC_W'(4);
      w_swap    = 1'b0;
      if (!w_stop) begin
        w_lane_vld[l] = 1'b1;
        case (w_inst[6:0])
          INST_BR: w_cls = IS_BRANCH;
          INST_JAL: begin
            w_cls = w_rd_lnk ? IS_CALL : IS_JAL;
            w_tgt = w_lane_pc + f_j_imm(w_inst);
          end
          INST_JALR: begin
            if (w_rs1_lnk && !w_rd_lnk) begin
              w_cls = IS_RET;
            end else if (w_rd_lnk && w_pend_vld) begin
              w_cls = IS_CALL;
              w_tgt = w_pend_val + f_i_imm(w_inst);
            end else if (w_rd_lnk && w_rs1_lnk && (w_inst[11:7] != w_inst[19:15])) begin
              w_cls  = IS_RET;
              w_swap = 1'b1;
            end else begin
              w_cls = IS_JALR;
            end
          end
          default: w_cls = IS_NORMAL;
        endcase

        if ((w_inst[6:0] == INST_LUI) && w_rd_lnk) begin
          w_pend_vld = 1'b1;
          w_pend_val = f_u_imm(w_inst);
        end else if ((w_inst[6:0] == INST_AUIPC) && w_rd_lnk) begin
          w_pend_vld = 1'b1;
          w_pend_val = w_lane_pc + f_u_imm(w_inst);
        end else begin
          w_pend_vld = 1'b0;
        end

        w_type[l] = w_cls;
        if (w_cls inside {IS_JAL, IS_CALL, IS_RET}) begin
          w_stop = 1'b1;
          w_npc  = w_tgt;
`ifdef HPU_IF_RAS_EN
          w_link = w_lane_pc + PC_W'(4);
          if (w_cls == IS_CALL) begin
            w_ras_op = RAS_PUSH;
          end else if (w_cls == IS_RET) begin
            if (r_cnt != '0) begin
              w_npc    = r_ras[r_ptr - PTR_W'(1)];
              w_ras_op = w_swap ? RAS_SWAP : RAS_POP;
            end else if (w_swap) begin
              w_ras_op = RAS_PUSH;
            end
          end
`endif
        end
      end
    end
  end

  // Prediction outputs and link tracker.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_vld      <= 1'b0;
      r_lane_vld <= '0;
      for (int unsigned l = 0; l < FETCH_W; l++) r_type[l] <= IS_NORMAL;
      r_npc      <= '0;
      r_pend_vld <= 1'b0;
      r_pend_val <= '0;
    end else if (flush_i) begin
      r_vld      <= 1'b0;
      r_pend_vld <= 1'b0;
    end else if (!stall_i) begin
      r_vld <= fetch_vld_i;
      if (fetch_vld_i) begin
        r_lane_vld <= w_lane_vld;
        r_type     <= w_type;
        r_npc      <= w_npc;
        r_pend_vld <= w_pend_vld;
        r_pend_val <= w_pend_val;
      end
    end
  end

`ifdef HPU_IF_RAS_EN
  // Circular RAS; ptr is the next free slot, cnt saturates so the oldest entry is overwritten.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_ckpt <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (flush_i) begin
      {r_ptr, r_cnt} <= flush_ckpt_i;
    end else if (!stall_i && fetch_vld_i) begin
      r_ckpt <= {r_ptr, r_cnt};
      case (w_ras_op)
        RAS_PUSH: begin
          r_ras[r_ptr] <= w_link;
          r_ptr        <= r_ptr + PTR_W'(1);
          if (r_cnt != CNT_W'(RAS_DEPTH)) r_cnt <= r_cnt + CNT_W'(1);
        end
        RAS_POP: begin
          r_ptr <= r_ptr - PTR_W'(1);
          r_cnt <= r_cnt - CNT_W'(1);
        end
        RAS_SWAP: r_ras[r_ptr - PTR_W'(1)] <= w_link;
        default: ;
      endcase
    end
  end

  assign qdec_ckpt_o = r_ckpt;
`else
  assign qdec_ckpt_o = '0;
`endif

  assign qdec_vld_o      = r_vld;
  assign qdec_lane_vld_o = r_lane_vld;
  assign qdec_type_o     = r_type;
  assign qdec_pred_npc_o = r_npc;

endmodule

// File: tb/tb_hpu_if_qdec_ras.sv
// Scoreboard bench for hpu_if_qdec_ras: randomized and directed packets against a behavioural model.
module tb_hpu_if_qdec_ras;
  import hpu_if_qdec_ras_pkg::*;

  localparam int unsigned FETCH_W   = 2;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned PTR_W     = 3;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned CKPT_W    = PTR_W + CNT_W;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;

  typedef struct packed {
    logic [FETCH_W-1:0]      lv;
    logic [FETCH_W-1:0][2:0] ty;
    pc_t                     npc;
    logic [CKPT_W-1:0]       ck;
  } exp_t;

  logic                     clk_i = 1'b0;
  logic                     rst_n_i;
  logic                     fetch_vld_i;
  inst_t      [FETCH_W-1:0] fetch_inst_i;
  pc_t                      fetch_pc_i;
  logic                     stall_i;
  logic                     flush_i;
  logic       [CKPT_W-1:0]  flush_ckpt_i;
  logic                     qdec_vld_o;
  logic       [FETCH_W-1:0] qdec_lane_vld_o;
  qdec_type_e [FETCH_W-1:0] qdec_type_o;
  pc_t                      qdec_pred_npc_o;
  logic       [CKPT_W-1:0]  qdec_ckpt_o;

  hpu_if_qdec_ras #(.FETCH_W(FETCH_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .fetch_vld_i(fetch_vld_i), .fetch_inst_i(fetch_inst_i),
    .fetch_pc_i(fetch_pc_i), .stall_i(stall_i), .flush_i(flush_i), .flush_ckpt_i(flush_ckpt_i),
    .qdec_vld_o(qdec_vld_o), .qdec_lane_vld_o(qdec_lane_vld_o), .qdec_type_o(qdec_type_o),
    .qdec_pred_npc_o(qdec_pred_npc_o), .qdec_ckpt_o(qdec_ckpt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  exp_t exp_q[$];
  logic [CKPT_W-1:0] ck_hist[$];

  // Reference state: stack memory, next-free index, depth, pending link value.
  pc_t m_mem [RAS_DEPTH];
  int  m_ptr, m_cnt;
  bit  m_pend;
  pc_t m_pval;
  logic [CKPT_W-1:0] m_last_ck;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic inst_t enc_j(input logic [4:0] rd, input logic [20:0] im);
    return {im[20], im[10:1], im[11], im[19:12], rd, INST_JAL};
  endfunction
  function automatic inst_t enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [11:0] im);
    return {im, rs1, 3'b000, rd, op};
  endfunction
  function automatic inst_t enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] im);
    return {im, rd, op};
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return SR_RA;
      1: return SR_T0;
      2: return 5'd0;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic inst_t rnd_inst();
    logic [4:0] rd, rs1;
    rd  = pick_reg();
    rs1 = pick_reg();
    case ($urandom_range(0, 9))
      0:       return enc_j(rd, 21'($urandom) & 21'h1ffffe);
      1, 2:    return enc_i(INST_JALR, rd, rs1, 12'($urandom));
      3:       return enc_u(INST_LUI, rd, 20'($urandom));
      4:       return enc_u(INST_AUIPC, rd, 20'($urandom));
      5:       return {25'($urandom), INST_BR};
      default: return enc_i(OP_IMM, rd, rs1, 12'($urandom));
    endcase
  endfunction

  function automatic bit is_lnk(input logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < RAS_DEPTH; i++) m_mem[i] = '0;
    m_ptr = 0; m_cnt = 0; m_pend = 0; m_pval = '0;
  endfunction

  function automatic void m_push(input pc_t v);
`ifdef HPU_IF_RAS_EN
    m_mem[m_ptr] = v;
    m_ptr = (m_ptr + 1) % RAS_DEPTH;
    if (m_cnt < RAS_DEPTH) m_cnt++;
`else
    if (v == '1) m_pval = v;
`endif
  endfunction

  // Return target; swap replaces the top instead of popping it.
  function automatic pc_t m_ret(input pc_t lpc, input bit swap);
`ifdef HPU_IF_RAS_EN
    int  top;
    pc_t v;
    if (m_cnt > 0) begin
      top = (m_ptr + RAS_DEPTH - 1) % RAS_DEPTH;
      v = m_mem[top];
      if (swap) m_mem[top] = lpc + 4;
      else begin m_ptr = top; m_cnt--; end
      return v;
    end
    if (swap) m_push(lpc + 4);
`else
    if (swap && lpc == '1) m_pend = 0;
`endif
    return lpc + 4;
  endfunction

  function automatic exp_t m_packet(input pc_t pc, input inst_t ins [FETCH_W]);
    exp_t e;
    bit stop;
    pc_t lpc;
    inst_t x;
    qdec_type_e t;
    int ji, ii;
    e = '0;
    stop = 0;
    e.npc = pc + 32'(4 * FETCH_W);
`ifdef HPU_IF_RAS_EN
    e.ck = {PTR_W'(m_ptr), CNT_W'(m_cnt)};
`endif
    for (int l = 0; l < FETCH_W && !stop; l++) begin
      lpc = pc + 32'(4 * l);
      x = ins[l];
      ji = $signed({x[31], x[19:12], x[20], x[30:21], 1'b0});
      ii = $signed(x[31:20]);
      t = IS_NORMAL;
      e.lv[l] = 1'b1;
      if (x[6:0] == INST_BR) t = IS_BRANCH;
      else if (x[6:0] == INST_JAL) begin
        t = is_lnk(x[11:7]) ? IS_CALL : IS_JAL;
        e.npc = lpc + 32'(ji);
        if (t == IS_CALL) m_push(lpc + 4);
        stop = 1;
      end else if (x[6:0] == INST_JALR) begin
        if (is_lnk(x[19:15]) && !is_lnk(x[11:7])) begin
          t = IS_RET; e.npc = m_ret(lpc, 0); stop = 1;
        end else if (is_lnk(x[11:7]) && m_pend) begin
          t = IS_CALL; e.npc = m_pval + 32'(ii); m_push(lpc + 4); stop = 1;
        end else if (is_lnk(x[11:7]) && is_lnk(x[19:15]) && x[11:7] != x[19:15]) begin
          t = IS_RET; e.npc = m_ret(lpc, 1); stop = 1;
        end else t = IS_JALR;
      end
      e.ty[l] = t;
      if (x[6:0] == INST_LUI && is_lnk(x[11:7])) begin
        m_pend = 1; m_pval = {x[31:12], 12'h0};
      end else if (x[6:0] == INST_AUIPC && is_lnk(x[11:7])) begin
        m_pend = 1; m_pval = lpc + {x[31:12], 12'h0};
      end else m_pend = 0;
    end
    return e;
  endfunction

  task automatic step(input logic v, input pc_t pc, input inst_t ins [FETCH_W], input logic s,
                      input logic f, input logic [CKPT_W-1:0] ck);
    exp_t e;
    @(negedge clk_i);
    fetch_vld_i = v; fetch_pc_i = pc; stall_i = s; flush_i = f; flush_ckpt_i = ck;
    for (int l = 0; l < FETCH_W; l++) fetch_inst_i[l] = ins[l];
    if (f) begin
      m_pend = 0;
`ifdef HPU_IF_RAS_EN
      m_ptr = int'(ck[CKPT_W-1:CNT_W]);
      m_cnt = int'(ck[CNT_W-1:0]);
`endif
    end else if (v && !s) begin
      e = m_packet(pc, ins);
      m_last_ck = e.ck;
      ck_hist.push_back(e.ck);
      if (ck_hist.size() > 16) void'(ck_hist.pop_front());
      exp_q.push_back(e);
    end
  endtask

  task automatic pk2(input pc_t pc, input inst_t a, input inst_t b);
    inst_t p [FETCH_W];
    p[0] = a; p[1] = b;
    step(1'b1, pc, p, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    inst_t p [FETCH_W];
    p[0] = '0; p[1] = '0;
    repeat (n) step(1'b0, '0, p, 1'b0, 1'b0, '0);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_vld"}, 64'(qdec_vld_o), 64'(0));
    chk({nm, "_lane_vld"}, 64'(qdec_lane_vld_o), 64'(0));
    chk({nm, "_type"}, 64'(qdec_type_o), 64'(0));
    chk({nm, "_npc"}, 64'(qdec_pred_npc_o), 64'(0));
    chk({nm, "_ckpt"}, 64'(qdec_ckpt_o), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0; fetch_vld_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    #1;
    check_reset("reset_mid");
    m_reset();
    exp_q.delete();
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Monitor: compare fresh outputs against the scoreboard, and held outputs during stalls.
  initial begin
    exp_t e;
    bit adv, held;
    logic [63:0] snap, cur;
    snap = '0;
    forever begin
      @(posedge clk_i);
      adv  = rst_n_i && (flush_i || !stall_i);
      held = rst_n_i && stall_i && !flush_i;
      #1;
      cur = 64'({qdec_vld_o, qdec_lane_vld_o, qdec_type_o, qdec_pred_npc_o, qdec_ckpt_o});
      if (held) chk("stall_hold", cur, snap);
      if (adv && qdec_vld_o) begin
        if (exp_q.size() == 0) chk("unexpected_vld", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("lane_vld", 64'(qdec_lane_vld_o), 64'(e.lv));
          chk("pred_npc", 64'(qdec_pred_npc_o), 64'(e.npc));
          chk("ckpt", 64'(qdec_ckpt_o), 64'(e.ck));
          for (int l = 0; l < FETCH_W; l++)
            if (e.lv[l]) chk("type", 64'(3'(qdec_type_o[l])), 64'(e.ty[l]));
        end
      end else if (adv && exp_q.size() != 0) begin
        chk("missing_vld", 64'(0), 64'(1));
        void'(exp_q.pop_front());
      end
      snap = cur;
    end
  end

  initial begin
    inst_t addi, ret, p [FETCH_W];
    logic [CKPT_W-1:0] saved;
    rst_n_i = 1'b0; fetch_vld_i = 1'b0; fetch_pc_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    flush_ckpt_i = '0; fetch_inst_i = '0; m_last_ck = '0;
    m_reset();
    addi = enc_i(OP_IMM, 5'd10, 5'd10, 12'h001);
    ret  = enc_i(INST_JALR, 5'd0, SR_RA, 12'h000);
    repeat (2) @(negedge clk_i);
    check_reset("reset_init");
    rst_n_i = 1'b1;

    pk2(32'h1000, enc_j(SR_RA, 21'h100), addi);
    pk2(32'h2000, enc_u(INST_AUIPC, SR_RA, 20'h1), enc_i(INST_JALR, SR_RA, SR_RA, 12'h010));
    for (int i = 0; i < 9; i++) pk2(32'h5000 + 32'(i * 64), enc_j(SR_RA, 21'h200), addi);
    for (int i = 0; i < 9; i++) pk2(32'h8000 + 32'(i * 16), ret, addi);

    // Checkpoint restore after reset mid-operation.
    do_reset();
    pk2(32'h4000, enc_j(SR_RA, 21'h040), addi);
    saved = m_last_ck;
    p[0] = addi; p[1] = addi;
    step(1'b0, '0, p, 1'b0, 1'b1, saved);
    pk2(32'h4100, ret, addi);

    // Flush beats stall and valid, and drops a pending link value.
    pk2(32'h6000, addi, enc_u(INST_LUI, SR_T0, 20'h7));
    p[0] = enc_j(SR_RA, 21'h080); p[1] = addi;
    step(1'b1, 32'h6008, p, 1'b1, 1'b1, saved);
    pk2(32'h6008, enc_i(INST_JALR, SR_T0, SR_T0, 12'h004), addi);
    pk2(32'h7000, enc_j(SR_RA, 21'h010), addi);
    pk2(32'h7010, enc_i(INST_JALR, SR_RA, SR_T0, 12'h000), addi);
    pk2(32'h7020, addi, ret);
    p[0] = enc_j(SR_RA, 21'h020); p[1] = addi;
    repeat (3) step(1'b1, 32'h7100, p, 1'b1, 1'b0, '0);
    idle(2);

    for (int n = 0; n < 1500; n++) begin
      logic v, s, f;
      logic [CKPT_W-1:0] ck;
      for (int l = 0; l < FETCH_W; l++) p[l] = rnd_inst();
      v = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 19) == 0);
      ck = (ck_hist.size() > 0) ? ck_hist[$urandom_range(0, ck_hist.size() - 1)] : '0;
      step(v, $urandom & 32'hffff_fffc, p, s, f, ck);
      if (n == 700) do_reset();
    end
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
